// File: rtl/layer_line_reader.sv
// Composer-side line-buffer reader: walks a fractional read position across the
// active width and realigns the one-clock-late buffer data into a pixel stream.
module layer_line_reader #(
    parameter int H_ACTIVE  = 640,
    parameter int IDX_WIDTH = 10,
    parameter int FRAC_BITS = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 line_start,
    input  logic [IDX_WIDTH-1:0] start_idx,
    input  logic [7:0]           hscale,
    output logic [IDX_WIDTH-1:0] composer_rd_idx,
    input  logic [7:0]           composer_rd_data,
    output logic [7:0]           pix_data,
    output logic                 pix_valid,
    output logic                 pix_last,
    output logic                 busy
);

    localparam int POS_W = IDX_WIDTH + FRAC_BITS;

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state;
    logic [POS_W-1:0]     pos;
    logic [IDX_WIDTH-1:0] cnt;
    logic                 issue_v;
    logic                 issue_last;
    logic                 last_read;

    assign composer_rd_idx = pos[POS_W-1:FRAC_BITS];
    assign busy            = (state == RUN);
    assign last_read       = (cnt == IDX_WIDTH'(H_ACTIVE - 1));

    // A line_start cycle (from IDLE or aborting a running line) only reloads the
    // position; reads of the new line begin on the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pos        <= '0;
            cnt        <= '0;
            issue_v    <= 1'b0;
            issue_last <= 1'b0;
            pix_data   <= '0;
            pix_valid  <= 1'b0;
            pix_last   <= 1'b0;
        end else begin
            issue_v    <= 1'b0;
            issue_last <= 1'b0;
            pix_valid  <= issue_v;
            pix_last   <= issue_last;
            if (issue_v) begin
                pix_data <= composer_rd_data;
            end

            case (state)
                IDLE: begin
                    if (line_start) begin
                        pos   <= {start_idx, {FRAC_BITS{1'b0}}};
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (line_start) begin
                        pos <= {start_idx, {FRAC_BITS{1'b0}}};
                        cnt <= '0;
                    end else begin
                        issue_v    <= 1'b1;
                        issue_last <= last_read;
                        pos        <= pos + POS_W'(hscale);
                        cnt        <= cnt + 1'b1;
                        if (last_read) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
